// File: rtl/fxp_div_iter_if.sv
// Operand/result handshake bundle for fxp_div_iter: operand channel (i_valid/o_ready)
// and result channel (o_valid/i_ready), named from the divider's point of view.
interface fxp_div_iter_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_quotient;
  logic [TAG_W-1:0] o_tag;
  logic             o_div_zero;
  logic             o_overflow;

  modport master (
    output i_valid, i_dividend, i_divisor, i_tag, i_ready,
    input  o_ready, o_valid, o_quotient, o_tag, o_div_zero, o_overflow
  );

  modport slave (
    input  i_valid, i_dividend, i_divisor, i_tag, i_ready,
    output o_ready, o_valid, o_quotient, o_tag, o_div_zero, o_overflow
  );

endinterface

// File: rtl/fxp_div_iter.sv
// Iterative signed fixed-point divider: restoring division, one quotient bit per cycle.
// Define FXP_DIV_SAT_EN to saturate on overflow and flag o_overflow; otherwise results wrap.
module fxp_div_iter #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int TAG_W = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  fxp_div_iter_if.slave bus
);

  localparam int N     = WIDTH + FRAC;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    SIGN   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_r;
  logic             ready_r;
  logic             sign_r;
  logic [WIDTH-1:0] mag_b_r;
  logic [WIDTH-1:0] rem_r;
  logic [N-1:0]     dq_r;
  logic [CNT_W-1:0] cnt_r;

  logic             valid_r;
  logic [WIDTH-1:0] quot_r;
  logic [TAG_W-1:0] tag_r;
  logic             dz_r;
  logic             ovf_r;

  logic             accept_s;
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   trial_s;
  logic             fits_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] wrap_s;
  logic [WIDTH-1:0] result_s;
  logic             ovf_s;

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1) exactly.
  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      return ~v + WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

`ifdef FXP_DIV_SAT_EN
  // A negative result may reach magnitude 2^(WIDTH-1); a positive one stops one short.
  function automatic logic quot_overflow(input logic neg, input logic [N-1:0] q);
    if (neg) begin
      return (|q[N-1:WIDTH]) | (q[WIDTH-1] & (|q[WIDTH-2:0]));
    end else begin
      return |q[N-1:WIDTH-1];
    end
  endfunction
`endif

  assign accept_s = bus.i_valid & ready_r;

  // dq_r holds the shifted dividend in its upper bits and collects quotient bits at the bottom.
  assign rem_shift_s = {rem_r, dq_r[N-1]};
  assign trial_s     = rem_shift_s - {1'b0, mag_b_r};
  assign fits_s      = ~trial_s[WIDTH];
  assign rem_next_s  = fits_s ? trial_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];

  assign wrap_s = sign_r ? (~dq_r[WIDTH-1:0] + WIDTH'(1)) : dq_r[WIDTH-1:0];

`ifdef FXP_DIV_SAT_EN
  // Final result selection with saturation on out-of-range quotients.
  always_comb begin
    ovf_s    = quot_overflow(sign_r, dq_r);
    result_s = wrap_s;
    if (ovf_s) begin
      result_s = sign_r ? MIN_NEG : MAX_POS;
    end else begin
      result_s = wrap_s;
    end
  end
`else
  assign ovf_s    = 1'b0;
  assign result_s = wrap_s;
`endif

  // Control FSM, division datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      sign_r  <= 1'b0;
      mag_b_r <= {WIDTH{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      dq_r    <= {N{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      valid_r <= 1'b0;
      quot_r  <= {WIDTH{1'b0}};
      tag_r   <= {TAG_W{1'b0}};
      dz_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            ready_r <= 1'b0;
            tag_r   <= bus.i_tag;
            if (bus.i_divisor == {WIDTH{1'b0}}) begin
              // Divide by zero skips the datapath; DONE raises o_valid one edge later.
              state_r <= DONE;
              quot_r  <= bus.i_dividend[WIDTH-1] ? MIN_NEG : MAX_POS;
              dz_r    <= 1'b1;
              ovf_r   <= 1'b0;
            end else begin
              state_r <= DIVIDE;
              sign_r  <= bus.i_dividend[WIDTH-1] ^ bus.i_divisor[WIDTH-1];
              mag_b_r <= abs_mag(bus.i_divisor);
              dq_r    <= {abs_mag(bus.i_dividend), {FRAC{1'b0}}};
              rem_r   <= {WIDTH{1'b0}};
              cnt_r   <= {CNT_W{1'b0}};
            end
          end
        end
        DIVIDE: begin
          rem_r <= rem_next_s;
          dq_r  <= {dq_r[N-2:0], fits_s};
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            state_r <= SIGN;
          end
        end
        SIGN: begin
          state_r <= DONE;
          quot_r  <= result_s;
          ovf_r   <= ovf_s;
          dz_r    <= 1'b0;
          valid_r <= 1'b1;
        end
        DONE: begin
          if (!valid_r) begin
            valid_r <= 1'b1;
          end else if (bus.i_ready) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Reset is synchronous, so o_ready is gated to stay low for the whole time reset is held.
  assign bus.o_ready    = ready_r & i_rst_n;
  assign bus.o_valid    = valid_r;
  assign bus.o_quotient = quot_r;
  assign bus.o_tag      = tag_r;
  assign bus.o_div_zero = dz_r;
  assign bus.o_overflow = ovf_r;

endmodule
